// File: rtl/gpr_wb_ctrl.sv
// gpr_wb_ctrl: GPR writeback arbiter with 2-entry load FIFO and busy scoreboard; define WB_LOAD_BYPASS_EN to let loads skip an empty FIFO
module gpr_wb_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic        iss_hazard,
  output logic [31:0] busy,
  output logic        gpr_we_n,
  output logic [4:0]  gpr_wr_addr,
  output logic [31:0] gpr_wr_data
);
  logic [4:0]  f_addr [2];
  logic [31:0] f_data [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic [31:0] busy_q, set_mask, clr_mask;
  logic        push, pop, byp, sel_v;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  assign ld_ready = count != 2'd2;
`ifdef WB_LOAD_BYPASS_EN
  assign byp = ld_valid && ld_ready && !alu_valid && count == 2'd0;
`else
  assign byp = 1'b0;
`endif
  assign push = ld_valid && ld_ready && !byp;
  assign pop = !alu_valid && count != 2'd0;
  assign busy = {busy_q[31:1], 1'b0};
  assign iss_hazard = iss_valid && busy[iss_addr] && iss_addr != 5'd0;
  // pick the single write for this cycle: ALU first, then FIFO head, then a bypassed load
  always_comb begin
    sel_v = alu_valid || pop || byp;
    sel_addr = alu_valid ? alu_addr : pop ? f_addr[rd_ptr] : ld_addr;
    sel_data = alu_valid ? alu_data : pop ? f_data[rd_ptr] : ld_data;
    clr_mask = sel_v ? 32'd1 << sel_addr : 32'd0;
    set_mask = (iss_valid && iss_addr != 5'd0) ? 32'd1 << iss_addr : 32'd0;
  end
  // FIFO payload storage; contents are don't-care until count says otherwise
  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wr_ptr] <= ld_addr;
      f_data[wr_ptr] <= ld_data;
    end
  end
  // FIFO pointers/count, scoreboard and registered GPR write port
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
      busy_q <= 32'd0;
      gpr_we_n <= 1'b1;
      gpr_wr_addr <= 5'd0;
      gpr_wr_data <= 32'd0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
      busy_q <= (busy_q & ~clr_mask) | set_mask;
      gpr_we_n <= !(sel_v && sel_addr != 5'd0);
      if (sel_v && sel_addr != 5'd0) begin
        gpr_wr_addr <= sel_addr;
        gpr_wr_data <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// tb_gpr_wb_ctrl: directed self-checking bench for gpr_wb_ctrl
module tb_gpr_wb_ctrl;
  logic        clk = 0, reset = 1;
  logic        alu_valid = 0, ld_valid = 0, iss_valid = 0;
  logic [4:0]  alu_addr = 0, ld_addr = 0, iss_addr = 0;
  logic [31:0] alu_data = 0, ld_data = 0;
  logic        ld_ready, iss_hazard, gpr_we_n;
  logic [31:0] busy, gpr_wr_data;
  logic [4:0]  gpr_wr_addr;
  int checks = 0, failures = 0;

  gpr_wb_ctrl dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_hazard(iss_hazard),
    .busy(busy), .gpr_we_n(gpr_we_n), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; ld_valid = 0; iss_valid = 0;
  endtask

  task automatic expect_wr(input string name, input logic we_n, input logic [4:0] a, input logic [31:0] d);
    checks++;
    if (gpr_we_n !== we_n || (!we_n && (gpr_wr_addr !== a || gpr_wr_data !== d))) begin
      failures++;
      $display("FAIL %s: got we_n=%b addr=%0d data=%h, want we_n=%b addr=%0d data=%h",
               name, gpr_we_n, gpr_wr_addr, gpr_wr_data, we_n, a, d);
    end
  endtask

  task automatic test_reset();
    reset = 1; alu_valid = 1; alu_addr = 3; alu_data = 32'h55; iss_valid = 1; iss_addr = 4;
    step(); step();
    checks++;
    if (gpr_we_n !== 1 || gpr_wr_addr !== 0 || gpr_wr_data !== 0 || busy !== 0 || ld_ready !== 1) begin
      failures++;
      $display("FAIL reset_state: we_n=%b addr=%0d data=%h busy=%h ld_ready=%b, want 1/0/0/0/1",
               gpr_we_n, gpr_wr_addr, gpr_wr_data, busy, ld_ready);
    end
    idle(); reset = 0;
    step();
    expect_wr("reset_release", 1, 0, 0);
  endtask

  task automatic test_alu();
    iss_valid = 1; iss_addr = 5;
    step(); idle();
    checks++;
    if (busy !== 32'h20) begin failures++; $display("FAIL alu_busy_set: busy=%h want 00000020", busy); end
    alu_valid = 1; alu_addr = 5; alu_data = 32'h12345678;
    step(); idle();
    expect_wr("alu_write", 0, 5, 32'h12345678);
    checks++;
    if (busy !== 0) begin failures++; $display("FAIL alu_busy_clr: busy=%h want 0", busy); end
    step();
    expect_wr("alu_one_cycle", 1, 0, 0);
    checks++;
    if (gpr_wr_addr !== 5 || gpr_wr_data !== 32'h12345678) begin
      failures++; $display("FAIL alu_hold: addr=%0d data=%h want 5/12345678", gpr_wr_addr, gpr_wr_data);
    end
  endtask

  task automatic test_load();
    ld_valid = 1; ld_addr = 7; ld_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (ld_ready !== 1) begin failures++; $display("FAIL load_ready: ld_ready=%b want 1", ld_ready); end
    step(); idle();
`ifdef WB_LOAD_BYPASS_EN
    expect_wr("load_bypass", 0, 7, 32'hDEADBEEF);
    step();
    expect_wr("load_after", 1, 0, 0);
`else
    expect_wr("load_t1", 1, 0, 0);
    step();
    expect_wr("load_t2", 0, 7, 32'hDEADBEEF);
    step();
    expect_wr("load_after", 1, 0, 0);
`endif
    checks++;
    if (ld_ready !== 1) begin failures++; $display("FAIL load_ready_end: ld_ready=%b want 1", ld_ready); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_addr = 5'(1 + i); alu_data = 32'hA0 + i;
      ld_valid = 1; ld_addr = 5'(10 + i); ld_data = 32'hB0 + i;
      #1;
      checks++;
      if (ld_ready !== (i < 2)) begin
        failures++; $display("FAIL b2b_ready%0d: ld_ready=%b want %b", i, ld_ready, i < 2);
      end
      step();
      expect_wr($sformatf("b2b_alu%0d", i), 0, 5'(1 + i), 32'hA0 + i);
    end
    idle();
    step();
    expect_wr("b2b_drain0", 0, 10, 32'hB0);
    step();
    expect_wr("b2b_drain1", 0, 11, 32'hB1);
    step();
    expect_wr("b2b_empty", 1, 0, 0);
  endtask

  task automatic test_r0();
    alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFFFFFF;
    step(); idle();
    expect_wr("r0_alu", 1, 0, 0);
    checks++;
    if (busy !== 0) begin failures++; $display("FAIL r0_busy: busy=%h want 0", busy); end
  endtask

  task automatic test_hazard();
    iss_valid = 1; iss_addr = 9;
    #1;
    checks++;
    if (iss_hazard !== 0) begin failures++; $display("FAIL hazard_first: iss_hazard=%b want 0", iss_hazard); end
    step();
    #1;
    checks++;
    if (iss_hazard !== 1) begin failures++; $display("FAIL hazard_second: iss_hazard=%b want 1", iss_hazard); end
    step();
    alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
    step(); idle();
    expect_wr("hazard_write", 0, 9, 32'h99);
    checks++;
    if (busy !== 32'h200) begin failures++; $display("FAIL hazard_set_wins: busy=%h want 00000200", busy); end
  endtask

  task automatic test_reset_full();
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1; alu_addr = 5'(1 + i); alu_data = 32'h1;
      ld_valid = 1; ld_addr = 5'(20 + i); ld_data = 32'hC0 + i;
      iss_valid = 1; iss_addr = 3;
      step();
    end
    #1;
    checks++;
    if (ld_ready !== 0) begin failures++; $display("FAIL full_before_reset: ld_ready=%b want 0", ld_ready); end
    reset = 1;
    step(); step();
    reset = 0; idle();
    checks++;
    if (busy !== 0 || ld_ready !== 1 || gpr_we_n !== 1) begin
      failures++; $display("FAIL full_reset: busy=%h ld_ready=%b we_n=%b want 0/1/1", busy, ld_ready, gpr_we_n);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      expect_wr($sformatf("full_no_write%0d", i), 1, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_r0();
    test_hazard();
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpr_wb_ctrl.md
GPR_WB_CTRL -- requirements
Module: gpr_wb_ctrl

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- alu_valid  in  1  single-cycle ALU result valid.
- alu_addr  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_valid  in  1  load result valid; accepted only when ld_ready=1.
- ld_addr  in  5  load destination register.
- ld_data  in  32  load result.
- ld_ready  out  1  load FIFO can accept; 1 when FIFO has a free entry.
- iss_valid  in  1  issue stage reserves a destination.
- iss_addr  in  5  register being reserved.
- iss_hazard  out  1  combinational; iss_valid and busy[iss_addr] and iss_addr!=0.
- busy  out  32  scoreboard; bit n = write to rn pending.
- gpr_we_n  out  1  GPR write enable, active-low, registered.
- gpr_wr_addr  out  5  GPR write address, registered.
- gpr_wr_data  out  32  GPR write data, registered.

Function
REQ-002 The block SHALL contain a 2-entry load FIFO (addr+data) with separate read and write pointers plus a count, wrapping modulo 2.
REQ-003 A load handshake SHALL occur when ld_valid=1 and ld_ready=1; ld_valid with ld_ready=0 SHALL be ignored (producer holds).
REQ-004 Each cycle, exactly one write SHALL be selected for the output register, priority: alu_valid, then FIFO head, then none.
REQ-005 A selected write SHALL appear on gpr_we_n=0/gpr_wr_addr/gpr_wr_data the cycle after selection, held for exactly one cycle; with none selected, gpr_we_n=1 and addr/data hold previous values.
REQ-006 The FIFO head SHALL be popped only in a cycle when alu_valid=0 and count>0.
REQ-007 A simultaneous push and pop SHALL be permitted with count unchanged; with count=2, ld_ready=0 even if a pop occurs that cycle (no full-bypass).
REQ-008 Writes to r0 (ALU or load) SHALL be consumed/popped normally but SHALL produce gpr_we_n=1.
REQ-009 busy[iss_addr] SHALL be set on the edge after iss_valid=1 for iss_addr!=0; busy[0] SHALL always read 0.
REQ-010 busy[n] SHALL clear on the edge where gpr_we_n goes to 0 with gpr_wr_addr=n is registered (i.e. when the write is selected).
REQ-011 Simultaneous set and clear of the same bit SHALL result in set (new reservation wins).
REQ-012 ALU and FIFO writes to the same register in consecutive cycles SHALL be emitted in selection order; no write SHALL be dropped or merged.

Reset
REQ-013 While reset=1 at a rising edge: gpr_we_n=1, gpr_wr_addr=0, gpr_wr_data=0, busy=0, FIFO count=0, pointers=0.
REQ-014 ld_ready SHALL be 1 in the cycle after reset deasserts; FIFO entries in flight at reset SHALL be discarded with no write emitted.
REQ-015 ALU, load and issue inputs sampled during reset SHALL be ignored.

Configuration
REQ-016 Macro WB_LOAD_BYPASS_EN: when defined, an accepted load with FIFO count=0 and alu_valid=0 SHALL be selected directly (GPR write one cycle after handshake, FIFO untouched); when undefined, every load SHALL pass through the FIFO (GPR write two cycles after handshake minimum).

Verification
REQ-017 Bench SHALL cover:
- ALU r5=0x12345678 at cycle t -> gpr_we_n=0, addr=5, data=0x12345678 at t+1 only; busy[5] cleared.
- Load r7=0xDEADBEEF alone -> write at t+2 (macro off) or t+1 (macro on); ld_ready stays 1.
- ALU valid 3 cycles while 3 loads offered -> 2 loads accepted, ld_ready=0 on third; loads drain in order after ALU stops.
- ALU r0=0xFFFFFFFF -> gpr_we_n stays 1; busy stays 0.
- iss r9 then iss r9 again before write -> iss_hazard=1 second time; write to r9 with same-cycle re-issue -> busy[9] remains 1.
- Reset asserted with FIFO count=2 -> no writes after reset, ld_ready=1, busy=0.
